// File: rtl/iecdrv_trackmem.sv
// Track memory for a disk-drive emulator: a byte-wide host port (A) and a
// bit-serial head port (B) over the same RAM, plus the rotating head counter.
// Port A is pipelined one cycle ahead of its RAM access. Port B accesses the RAM
// in the cycle it is presented. Both ports can hit one byte on the same edge,
// and their writes are merged so that neither port loses a bit.
module iecdrv_trackmem #(
  parameter int ADDRWIDTH = 13
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDRWIDTH-1:0] address_a,
  input  logic [7:0]           data_a,
  input  logic                 wren_a,
  output logic [7:0]           q_a,
  input  logic [ADDRWIDTH+2:0] track_len,
  input  logic                 head_rst,
  input  logic                 head_step,
  input  logic                 bit_wr,
  input  logic                 bit_din,
  output logic                 bit_dout,
  output logic [ADDRWIDTH+2:0] head_pos,
  output logic                 wrap
);

  localparam int HW    = ADDRWIDTH + 3;
  localparam int DEPTH = 1 << ADDRWIDTH;

  logic [7:0] mem [0:DEPTH-1];

  logic [ADDRWIDTH-1:0] addr_a_q, addr_a_d;
  logic [7:0]           data_a_q, data_a_d;
  logic                 wren_a_q, wren_a_d;
  logic [7:0]           q_a_q, q_a_d;
  logic [HW-1:0]        head_q, head_d;
  logic                 bit_dout_q, bit_dout_d;
  logic                 wrap_q, wrap_d;

  logic [ADDRWIDTH-1:0] b_byte;
  logic [2:0]           b_idx;
  logic                 a_we, b_we, same_byte;
  logic [7:0]           a_wdata, b_view, b_wdata;
  logic [HW-1:0]        lend;

  // Datapath: merge same-byte writes, form write-through read data, next head.
  always_comb begin
    b_byte    = head_q[HW-1:3];
    b_idx     = head_q[2:0];
    // Writes arriving while reset is high are dropped; memory itself is kept.
    a_we      = wren_a_q & ~reset;
    b_we      = bit_wr & ~reset;
    same_byte = (addr_a_q == b_byte);

    // Port B's bit overrides the host byte at its index on a collision.
    a_wdata = data_a_q;
    if (b_we && same_byte) a_wdata[b_idx] = bit_din;

    b_view  = (a_we && same_byte) ? a_wdata : mem[b_byte];
    b_wdata = b_view;
    if (b_we) b_wdata[b_idx] = bit_din;

    // A host read (no write) sees the byte as it was before this edge.
    q_a_d      = a_we ? a_wdata : mem[addr_a_q];
    bit_dout_d = b_wdata[b_idx];

    addr_a_d = address_a;
    data_a_d = data_a;
    wren_a_d = wren_a;

    // Zero track length means the whole RAM is one track.
    lend   = (track_len == '0) ? '1 : track_len - HW'(1);
    head_d = head_q;
    wrap_d = 1'b0;
    if (head_rst) begin
      head_d = '0;
    end else if (head_step) begin
      // ">=" also catches a head left beyond a freshly shortened track.
      if (head_q >= lend) begin
        head_d = '0;
        wrap_d = 1'b1;
      end else begin
        head_d = head_q + HW'(1);
      end
    end
  end

  // Control and output registers; reset clears them and cancels pending writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_a_q   <= '0;
      data_a_q   <= '0;
      wren_a_q   <= 1'b0;
      q_a_q      <= '0;
      head_q     <= '0;
      bit_dout_q <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      addr_a_q   <= addr_a_d;
      data_a_q   <= data_a_d;
      wren_a_q   <= wren_a_d;
      q_a_q      <= q_a_d;
      head_q     <= head_d;
      bit_dout_q <= bit_dout_d;
      wrap_q     <= wrap_d;
    end
  end

  // RAM update; on a same-byte collision both ports carry the identical merged byte.
  always_ff @(posedge clk) begin
    if (b_we) mem[b_byte]   <= b_wdata;
    if (a_we) mem[addr_a_q] <= a_wdata;
  end

  assign q_a      = q_a_q;
  assign bit_dout = bit_dout_q;
  assign head_pos = head_q;
  assign wrap     = wrap_q;

endmodule

// File: tb/tb_iecdrv_trackmem.sv
// Directed bench for iecdrv_trackmem: host port, serial head, wrap, collisions, reset.
module tb_iecdrv_trackmem;

  localparam int AW = 13;
  localparam int HW = AW + 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] address_a;
  logic [7:0]    data_a;
  logic          wren_a;
  logic [7:0]    q_a;
  logic [HW-1:0] track_len;
  logic          head_rst, head_step, bit_wr, bit_din;
  logic          bit_dout;
  logic [HW-1:0] head_pos;
  logic          wrap;

  int tests = 0;
  int fails = 0;

  iecdrv_trackmem #(.ADDRWIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .address_a(address_a), .data_a(data_a), .wren_a(wren_a), .q_a(q_a),
    .track_len(track_len), .head_rst(head_rst), .head_step(head_step),
    .bit_wr(bit_wr), .bit_din(bit_din), .bit_dout(bit_dout),
    .head_pos(head_pos), .wrap(wrap)
  );

  always #5 clk = ~clk;

  // One clock; inputs are changed and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Host write into the RAM, leaving the port idle after it lands.
  task automatic host_write(input logic [AW-1:0] a, input logic [7:0] d);
    address_a = a; data_a = d; wren_a = 1'b1;
    tick();
    wren_a = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tests++; if (head_pos !== '0) begin fails++; $display("FAIL reset_head got %0d exp 0", head_pos); end
    tests++; if (bit_dout !== 1'b0) begin fails++; $display("FAIL reset_dout got %0b exp 0", bit_dout); end
    tests++; if (q_a !== 8'h00) begin fails++; $display("FAIL reset_qa got %0h exp 0", q_a); end
    tests++; if (wrap !== 1'b0) begin fails++; $display("FAIL reset_wrap got %0b exp 0", wrap); end
  endtask

  task automatic test_port_a();
    address_a = 3; data_a = 8'hA5; wren_a = 1'b1;
    tick();
    wren_a = 1'b0; address_a = 3;
    tick();
    tests++; if (q_a !== 8'hA5) begin fails++; $display("FAIL porta_wt got %0h exp a5", q_a); end
    address_a = 5; data_a = 8'h3C; wren_a = 1'b1;
    tick();
    tests++; if (q_a !== 8'hA5) begin fails++; $display("FAIL porta_rd got %0h exp a5", q_a); end
    wren_a = 1'b0; address_a = 3;
    tick();
    tests++; if (q_a !== 8'h3C) begin fails++; $display("FAIL porta_wt2 got %0h exp 3c", q_a); end
    tick();
    tests++; if (q_a !== 8'hA5) begin fails++; $display("FAIL porta_rd2 got %0h exp a5", q_a); end
  endtask

  task automatic test_serial_read();
    logic [7:0] pat;
    pat = 8'h81;
    host_write(0, pat);
    head_rst = 1'b1;
    tick();
    head_rst = 1'b0; head_step = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      tests++; if (head_pos !== HW'(k)) begin fails++; $display("FAIL serial_pos[%0d] got %0d exp %0d", k, head_pos, k); end
      tests++; if (bit_dout !== pat[k-1]) begin fails++; $display("FAIL serial_bit[%0d] got %0b exp %0b", k, bit_dout, pat[k-1]); end
    end
    head_step = 1'b0;
  endtask

  task automatic test_wrap();
    int exp_pos, nwrap;
    nwrap = 0;
    track_len = 10; head_rst = 1'b1;
    tick();
    head_rst = 1'b0; head_step = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp_pos = (k <= 9) ? k : k - 10;
      if (wrap === 1'b1) nwrap++;
      tests++; if (head_pos !== HW'(exp_pos)) begin fails++; $display("FAIL wrap_pos[%0d] got %0d exp %0d", k, head_pos, exp_pos); end
      tests++; if (wrap !== (k == 10)) begin fails++; $display("FAIL wrap_pulse[%0d] got %0b exp %0b", k, wrap, (k == 10)); end
    end
    head_step = 1'b0;
    tests++; if (nwrap != 1) begin fails++; $display("FAIL wrap_count got %0d exp 1", nwrap); end
  endtask

  task automatic test_collision();
    // head to bit 2 of byte 0 (which holds 0x81)
    head_rst = 1'b1; tick(); head_rst = 1'b0;
    head_step = 1'b1; tick(); tick(); head_step = 1'b0;
    tests++; if (head_pos !== HW'(2)) begin fails++; $display("FAIL coll_pos got %0d exp 2", head_pos); end
    // host write registered now, lands together with the bit write next edge
    address_a = 0; data_a = 8'h00; wren_a = 1'b1;
    tick();
    wren_a = 1'b0; bit_wr = 1'b1; bit_din = 1'b1;
    tick();
    bit_wr = 1'b0;
    tests++; if (q_a !== 8'h04) begin fails++; $display("FAIL coll_qa got %0h exp 04", q_a); end
    tests++; if (bit_dout !== 1'b1) begin fails++; $display("FAIL coll_dout got %0b exp 1", bit_dout); end
    tick();
    tests++; if (q_a !== 8'h04) begin fails++; $display("FAIL coll_read got %0h exp 04", q_a); end
    // back-to-back bit writes at 2,3,4 all persist
    bit_wr = 1'b1; bit_din = 1'b1; head_step = 1'b1;
    tick(); tick(); tick();
    bit_wr = 1'b0; head_step = 1'b0;
    tick();
    tests++; if (q_a !== 8'h1C) begin fails++; $display("FAIL b2b_read got %0h exp 1c", q_a); end
    // host read colliding with a bit write at head 5 returns the old byte
    address_a = 0;
    bit_wr = 1'b1; bit_din = 1'b1;
    tick();
    bit_wr = 1'b0;
    tests++; if (q_a !== 8'h1C) begin fails++; $display("FAIL rd_pre got %0h exp 1c", q_a); end
    tick();
    tests++; if (q_a !== 8'h3C) begin fails++; $display("FAIL rd_post got %0h exp 3c", q_a); end
  endtask

  task automatic test_mid_reset();
    track_len = 0;
    host_write(4, 8'h5A);
    head_rst = 1'b1; tick(); head_rst = 1'b0;
    head_step = 1'b1;
    for (int k = 0; k < 37; k++) tick();
    head_step = 1'b0;
    tests++; if (head_pos !== HW'(37)) begin fails++; $display("FAIL mid_pos got %0d exp 37", head_pos); end
    // pending host write to byte 4, then reset with a bit write to byte 4 bit 5
    address_a = 4; data_a = 8'hFF; wren_a = 1'b1;
    tick();
    wren_a = 1'b0; reset = 1'b1; bit_wr = 1'b1; bit_din = 1'b1;
    tick();
    reset = 1'b0; bit_wr = 1'b0;
    tests++; if (head_pos !== '0) begin fails++; $display("FAIL mid_head got %0d exp 0", head_pos); end
    tests++; if (bit_dout !== 1'b0) begin fails++; $display("FAIL mid_dout got %0b exp 0", bit_dout); end
    tests++; if (wrap !== 1'b0) begin fails++; $display("FAIL mid_wrap got %0b exp 0", wrap); end
    tests++; if (q_a !== 8'h00) begin fails++; $display("FAIL mid_qa got %0h exp 0", q_a); end
    address_a = 4;
    tick(); tick();
    tests++; if (q_a !== 8'h5A) begin fails++; $display("FAIL mid_keep got %0h exp 5a", q_a); end
    head_step = 1'b1;
    tick();
    head_step = 1'b0;
    tests++; if (head_pos !== HW'(1)) begin fails++; $display("FAIL first_step got %0d exp 1", head_pos); end
  endtask

  task automatic test_shrink();
    track_len = 0; head_rst = 1'b1; tick(); head_rst = 1'b0;
    head_step = 1'b1;
    for (int k = 0; k < 50; k++) tick();
    head_step = 1'b0;
    tests++; if (head_pos !== HW'(50)) begin fails++; $display("FAIL shrink_pos got %0d exp 50", head_pos); end
    track_len = 20;
    tick();
    tests++; if (head_pos !== HW'(50) || wrap !== 1'b0) begin fails++; $display("FAIL shrink_hold got %0d/%0b exp 50/0", head_pos, wrap); end
    head_step = 1'b1;
    tick();
    tests++; if (head_pos !== '0 || wrap !== 1'b1) begin fails++; $display("FAIL shrink_wrap got %0d/%0b exp 0/1", head_pos, wrap); end
    tick();
    head_step = 1'b0;
    tests++; if (head_pos !== HW'(1) || wrap !== 1'b0) begin fails++; $display("FAIL shrink_next got %0d/%0b exp 1/0", head_pos, wrap); end
  endtask

  initial begin
    reset = 1'b0; address_a = '0; data_a = '0; wren_a = 1'b0;
    track_len = '0; head_rst = 1'b0; head_step = 1'b0;
    bit_wr = 1'b0; bit_din = 1'b0;
    #1;
    test_reset();
    test_port_a();
    test_serial_read();
    test_wrap();
    test_collision();
    test_mid_reset();
    test_shrink();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
